// File: rtl/regfile_mp.sv
// Multi-port integer register file with a fixed-priority dual write port,
// optional same-cycle write-to-read bypass, and a per-register pending scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRD*$clog2(NREG)-1:0] ra,
  output logic [NRD*XLEN-1:0]        rd,
  output logic [NRD-1:0]             rd_rdy,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [$clog2(NREG)-1:0]    wa0,
  input  logic [$clog2(NREG)-1:0]    wa1,
  input  logic [XLEN-1:0]            wd0,
  input  logic [XLEN-1:0]            wd1,
  input  logic                       alloc_en,
  input  logic [$clog2(NREG)-1:0]    alloc_a,
  output logic [$clog2(NREG):0]      pend_cnt
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int r = 0; r < NREG; r++) c = c + {{AW{1'b0}}, v[r]};
    return c;
  endfunction

  // A new producer supersedes one retiring in the same cycle, so alloc wins over clear.
  always_comb begin
    pending_nxt = pending;
    for (int r = 1; r < NREG; r++) begin
      if (alloc_en && alloc_a == AW'(r))
        pending_nxt[r] = 1'b1;
      else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r)))
        pending_nxt[r] = 1'b0;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      // Port 1 is assigned last so it wins an address collision.
      if (we0 && wa0 != '0) mem[wa0] <= wd0;
      if (we1 && wa1 != '0) mem[wa1] <= wd1;
      pending  <= pending_nxt;
      pend_cnt <= popcount(pending_nxt);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit0;
    logic          hit1;
    assign a    = ra[i*AW +: AW];
    assign hit1 = (BYPASS != 0) && we1 && (wa1 == a);
    assign hit0 = (BYPASS != 0) && we0 && (wa0 == a);
    assign rd[i*XLEN +: XLEN] = (a == '0) ? '0 :
                                hit1 ? wd1 :
                                hit0 ? wd0 : mem[a];
    assign rd_rdy[i] = (a == '0) || !pending[a] || hit1 || hit0;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances driven in parallel,
// checked against an array/flag reference model of the register file.
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 16;
  localparam int NRD  = 3;
  localparam int AW   = $clog2(NREG);

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] ra;
  logic              we0, we1, alloc_en;
  logic [AW-1:0]     wa0, wa1, alloc_a;
  logic [XLEN-1:0]   wd0, wd1;

  logic [NRD*XLEN-1:0] rd_b, rd_n;
  logic [NRD-1:0]      rdy_b, rdy_n;
  logic [AW:0]         cnt_b, cnt_n;

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend [NREG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rd_rdy(rdy_b),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_a(alloc_a), .pend_cnt(cnt_b));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rd_rdy(rdy_n),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_a(alloc_a), .pend_cnt(cnt_n));

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input bit bp, input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bp && we1 && wa1 == a) return wd1;
    if (bp && we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rdy(input bit bp, input logic [AW-1:0] a);
    if (a == 0) return 1'b1;
    if (!m_pend[a]) return 1'b1;
    return bp && ((we0 && wa0 == a) || (we1 && wa1 == a));
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
    return (AW+1)'(n);
  endfunction

  // Model of the clock edge: reset clears everything, else writes then alloc.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_pend[r] = 0; end
    end else begin
      if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_pend[wa0] = 0; end
      if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_pend[wa1] = 0; end
      if (alloc_en && alloc_a != 0) m_pend[alloc_a] = 1;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      check($sformatf("%s rd_b[%0d] ra=%0d", tag, i, a), rd_b[i*XLEN +: XLEN], exp_rd(1, a));
      check($sformatf("%s rd_n[%0d] ra=%0d", tag, i, a), rd_n[i*XLEN +: XLEN], exp_rd(0, a));
      check($sformatf("%s rdy_b[%0d]", tag, i), XLEN'(rdy_b[i]), XLEN'(exp_rdy(1, a)));
      check($sformatf("%s rdy_n[%0d]", tag, i), XLEN'(rdy_n[i]), XLEN'(exp_rdy(0, a)));
    end
    check({tag, " cnt_b"}, XLEN'(cnt_b), XLEN'(exp_cnt()));
    check({tag, " cnt_n"}, XLEN'(cnt_n), XLEN'(exp_cnt()));
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0; wa0 = '0; wa1 = '0; alloc_a = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic set_ra_all(input logic [AW-1:0] a);
    for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = a;
  endtask

  initial begin
    idle(); ra = '0; rst = 1'b1;
    for (int r = 0; r < NREG; r++) begin m_mem[r] = 'x; m_pend[r] = 0; end
    tick();
    rst = 1'b0;
    ra = {$urandom} % (1 << (NRD*AW));
    check_all("reset");
    check("reset rdy_b all ones", XLEN'(rdy_b), XLEN'({NRD{1'b1}}));

    // Fill r1..r15 with r+1 on port 0; bypass view sees it immediately.
    for (int r = 1; r < NREG; r++) begin
      we0 = 1; wa0 = AW'(r); wd0 = XLEN'(r + 1); set_ra_all(AW'(r));
      check_all("fill");
      tick();
    end
    idle();
    for (int r = 0; r < NREG; r++) begin
      set_ra_all(AW'(r));
      check_all("fill readback");
    end
    set_ra_all(AW'(7));
    #1 check("fill r7 literal", rd_n[0 +: XLEN], XLEN'(8));

    // Same-address collision on both write ports.
    we0 = 1; wa0 = 5; wd0 = 64'hAAAA_0000; we1 = 1; wa1 = 5; wd1 = 64'h5555_1111;
    set_ra_all(AW'(5));
    check_all("collide");
    check("collide bypass literal", rd_b[0 +: XLEN], 64'h5555_1111);
    tick(); idle();
    check_all("collide next");
    check("collide next literal", rd_n[0 +: XLEN], 64'h5555_1111);

    // Write r7 via port 1 while port 1 reads it.
    we1 = 1; wa1 = 7; wd1 = 64'hDEAD_BEEF; ra = {AW'(0), AW'(7), AW'(2)};
    check_all("r7 write");
    check("r7 bypass literal", rd_b[XLEN +: XLEN], 64'hDEAD_BEEF);
    check("r7 nobypass old", rd_n[XLEN +: XLEN], XLEN'(8));
    tick(); idle();
    check_all("r7 next");

    // Scoreboard: alloc r3, r4, r0.
    ra = {AW'(4), AW'(0), AW'(3)};
    alloc_en = 1; alloc_a = 3; check_all("alloc3 same"); tick();
    alloc_a = 4; check_all("alloc4 same"); tick();
    alloc_a = 0; check_all("alloc0 same"); tick();
    idle();
    check_all("alloc done");
    check("alloc cnt literal", XLEN'(cnt_b), XLEN'(2));
    we0 = 1; wa0 = 3; wd0 = 64'h1234;
    check_all("retire r3 same");
    tick(); idle();
    check_all("retire r3 next");
    check("retire cnt literal", XLEN'(cnt_n), XLEN'(1));

    // Alloc and write to an already-pending register in one cycle.
    alloc_en = 1; alloc_a = 9; tick();
    alloc_en = 1; alloc_a = 9; we0 = 1; wa0 = 9; wd0 = 64'h9999;
    ra = {AW'(9), AW'(4), AW'(9)};
    check_all("alloc+write r9 same");
    tick(); idle();
    check_all("alloc+write r9 next");
    check("r9 still pending", XLEN'(rdy_b[0]), XLEN'(0));

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = AW'($urandom); wa1 = AW'($urandom);
      wd0 = {$urandom, $urandom}; wd1 = {$urandom, $urandom};
      alloc_en = ($urandom_range(0, 3) == 0); alloc_a = AW'($urandom);
      ra = (NRD*AW)'($urandom);
      check_all("random");
      tick();
    end

    // Reset with a concurrent write must drop the write.
    idle(); rst = 1; we0 = 1; wa0 = 6; wd0 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    rst = 0; idle();
    for (int r = 0; r < NREG; r += 3) begin
      ra = {AW'(r), AW'(r + 1), AW'(6)};
      check_all("post reset");
    end
    check("post reset rdy_n all ones", XLEN'(rdy_n), XLEN'({NRD{1'b1}}));
    check("post reset r6 dropped", rd_n[0 +: XLEN], XLEN'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
